// File: rtl/frame_ram_arbiter.sv
// Shares the previous-frame RAM among three users: a capture read-before-write with
// old/new compare, a frame-clear engine, and a scan reader with a req/grant handshake.
module frame_ram_arbiter #(
  parameter int X_W          = 9,
  parameter int Y_W          = 8,
  parameter int DATA_W       = 3,
  parameter int ADDR_W       = 17,
  parameter int LINE_STRIDE  = 320,
  parameter int FRAME_PIXELS = 76800,
  parameter int READ_LAT     = 1
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              cap_valid,
  input  logic [X_W-1:0]    cap_x,
  input  logic [Y_W-1:0]    cap_y,
  input  logic [DATA_W-1:0] cap_data,
  output logic              cap_oob,
  output logic              cmp_valid,
  output logic [X_W-1:0]    cmp_x,
  output logic [Y_W-1:0]    cmp_y,
  output logic [DATA_W-1:0] cmp_old,
  output logic [DATA_W-1:0] cmp_new,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_rdaddress,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_CAP = 2'd1, TAG_SCAN = 2'd2} tag_kind_e;
  typedef enum logic [1:0] {CLR_IDLE = 2'd0, CLR_CLEAR = 2'd1, CLR_DONE = 2'd2} clr_state_e;

  typedef struct packed {
    tag_kind_e         kind;
    logic [ADDR_W-1:0] addr;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [DATA_W-1:0] data;
  } tag_t;

  logic              c1_valid_q, c1_valid_d;
  logic [ADDR_W-1:0] c1_addr_q, c1_addr_d;
  logic [X_W-1:0]    c1_x_q, c1_x_d;
  logic [Y_W-1:0]    c1_y_q, c1_y_d;
  logic [DATA_W-1:0] c1_data_q, c1_data_d;
  logic              cap_oob_q, cap_oob_d;
  logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;
  tag_t              tag_q [READ_LAT];
  tag_t              tag_d [READ_LAT];
  logic              cmp_valid_q, cmp_valid_d;
  logic [X_W-1:0]    cmp_x_q, cmp_x_d;
  logic [Y_W-1:0]    cmp_y_q, cmp_y_d;
  logic [DATA_W-1:0] cmp_old_q, cmp_old_d;
  logic [DATA_W-1:0] cmp_new_q, cmp_new_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] wraddr_q, wraddr_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;

  logic [31:0] cap_addr_full;
  logic        cap_in_range;
  tag_t        issue_tag;
  tag_t        done_tag;
  logic        cap_wr;
  logic        clr_wr;

  always_comb begin
    c1_valid_d  = 1'b0;
    c1_addr_d   = c1_addr_q;
    c1_x_d      = c1_x_q;
    c1_y_d      = c1_y_q;
    c1_data_d   = c1_data_q;
    cmp_valid_d = 1'b0;
    cmp_x_d     = cmp_x_q;
    cmp_y_d     = cmp_y_q;
    cmp_old_d   = cmp_old_q;
    cmp_new_d   = cmp_new_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    issue_tag   = '0;
    tag_d       = tag_q;

    // Range check on the full-width product so a wrapped address can never alias in range.
    cap_addr_full = 32'(cap_y) * 32'(LINE_STRIDE) + 32'(cap_x);
    cap_in_range  = (32'(cap_x) < 32'(LINE_STRIDE)) && (cap_addr_full < 32'(FRAME_PIXELS));
    cap_oob_d     = cap_oob_q | (cap_valid & ~cap_in_range);
    if (cap_valid && cap_in_range) begin
      c1_valid_d = 1'b1;
      c1_addr_d  = cap_addr_full[ADDR_W-1:0];
      c1_x_d     = cap_x;
      c1_y_d     = cap_y;
      c1_data_d  = cap_data;
    end

    rd_grant = resetn & rd_req & ~c1_valid_q;
    if (c1_valid_q) begin
      ram_rdaddress  = c1_addr_q;
      issue_tag      = '{kind: TAG_CAP, addr: c1_addr_q, x: c1_x_q, y: c1_y_q, data: c1_data_q};
    end else if (rd_grant) begin
      ram_rdaddress  = rd_addr;
      issue_tag.kind = TAG_SCAN;
    end else begin
      ram_rdaddress  = rdaddr_q;
    end
    rdaddr_d = ram_rdaddress;

    tag_d[0] = issue_tag;
    for (int i = 1; i < READ_LAT; i++) tag_d[i] = tag_q[i-1];
    done_tag = tag_q[READ_LAT-1];

    cap_wr = (done_tag.kind == TAG_CAP);
    if (cap_wr) begin
      cmp_valid_d = 1'b1;
      cmp_x_d     = done_tag.x;
      cmp_y_d     = done_tag.y;
      cmp_old_d   = ram_q;
      cmp_new_d   = done_tag.data;
    end
    if (done_tag.kind == TAG_SCAN) begin
      rd_valid_d = 1'b1;
      rd_data_d  = ram_q;
    end

    // The clear only advances on cycles the capture leaves the write port free.
    clr_wr = (state_q == CLR_CLEAR) && !cap_wr;
    case (state_q)
      CLR_IDLE: begin
        if (clr_start) begin
          state_d   = CLR_CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLR_CLEAR: begin
        if (clr_wr) begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == ADDR_W'(FRAME_PIXELS - 1)) state_d = CLR_DONE;
        end
      end
      CLR_DONE: state_d = CLR_IDLE;
      default:  state_d = CLR_IDLE;
    endcase
    clr_busy = (state_q == CLR_CLEAR);
    clr_done = (state_q == CLR_DONE);

    ram_wren = cap_wr | clr_wr;
    if (cap_wr) begin
      ram_wraddress = done_tag.addr;
      ram_data      = done_tag.data;
    end else if (clr_wr) begin
      ram_wraddress = clr_cnt_q;
      ram_data      = '0;
    end else begin
      ram_wraddress = wraddr_q;
      ram_data      = wrdata_q;
    end
    wraddr_d = ram_wraddress;
    wrdata_d = ram_data;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      c1_valid_q  <= 1'b0;
      c1_addr_q   <= '0;
      c1_x_q      <= '0;
      c1_y_q      <= '0;
      c1_data_q   <= '0;
      cap_oob_q   <= 1'b0;
      rdaddr_q    <= '0;
      for (int i = 0; i < READ_LAT; i++) tag_q[i] <= '0;
      cmp_valid_q <= 1'b0;
      cmp_x_q     <= '0;
      cmp_y_q     <= '0;
      cmp_old_q   <= '0;
      cmp_new_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      state_q     <= CLR_IDLE;
      clr_cnt_q   <= '0;
      wraddr_q    <= '0;
      wrdata_q    <= '0;
    end else begin
      c1_valid_q  <= c1_valid_d;
      c1_addr_q   <= c1_addr_d;
      c1_x_q      <= c1_x_d;
      c1_y_q      <= c1_y_d;
      c1_data_q   <= c1_data_d;
      cap_oob_q   <= cap_oob_d;
      rdaddr_q    <= rdaddr_d;
      for (int i = 0; i < READ_LAT; i++) tag_q[i] <= tag_d[i];
      cmp_valid_q <= cmp_valid_d;
      cmp_x_q     <= cmp_x_d;
      cmp_y_q     <= cmp_y_d;
      cmp_old_q   <= cmp_old_d;
      cmp_new_q   <= cmp_new_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      wraddr_q    <= wraddr_d;
      wrdata_q    <= wrdata_d;
    end
  end

  assign cap_oob   = cap_oob_q;
  assign cmp_valid = cmp_valid_q;
  assign cmp_x     = cmp_x_q;
  assign cmp_y     = cmp_y_q;
  assign cmp_old   = cmp_old_q;
  assign cmp_new   = cmp_new_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter with a behavioural 1-cycle-latency dual-port RAM.
module tb_frame_ram_arbiter;
  localparam int X_W = 9, Y_W = 8, DATA_W = 3, ADDR_W = 17;
  localparam int LINE_STRIDE = 320, FP = 3200, READ_LAT = 1;

  logic              CLOCK_50 = 1'b0;
  logic              resetn, cap_valid, clr_start, rd_req;
  logic [X_W-1:0]    cap_x;
  logic [Y_W-1:0]    cap_y;
  logic [DATA_W-1:0] cap_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              cap_oob, cmp_valid, clr_busy, clr_done, rd_grant, rd_valid, ram_wren;
  logic [X_W-1:0]    cmp_x;
  logic [Y_W-1:0]    cmp_y;
  logic [DATA_W-1:0] cmp_old, cmp_new, rd_data, ram_data;
  logic [DATA_W-1:0] ram_q = '0;
  logic [ADDR_W-1:0] ram_rdaddress, ram_wraddress;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cmp_cnt = 0, cmp_first = 0, cmp_last = 0, wr_cnt = 0, zero_wr_cnt = 0, done_cnt = 0;
  logic [DATA_W-1:0] log_old [1024];
  logic [DATA_W-1:0] log_new [1024];
  logic [X_W-1:0]    log_x   [1024];
  logic [Y_W-1:0]    log_y   [1024];

  logic              fill_req = 1'b0;
  logic [DATA_W-1:0] fill_val = '0;
  logic [DATA_W-1:0] mem [FP];

  frame_ram_arbiter #(
    .X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .LINE_STRIDE(LINE_STRIDE), .FRAME_PIXELS(FP), .READ_LAT(READ_LAT)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .cap_valid(cap_valid), .cap_x(cap_x), .cap_y(cap_y), .cap_data(cap_data), .cap_oob(cap_oob),
    .cmp_valid(cmp_valid), .cmp_x(cmp_x), .cmp_y(cmp_y), .cmp_old(cmp_old), .cmp_new(cmp_new),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_rdaddress(ram_rdaddress), .ram_wraddress(ram_wraddress), .ram_wren(ram_wren),
    .ram_data(ram_data), .ram_q(ram_q)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    cyc <= cyc + 1;
    if (fill_req) begin
      for (int i = 0; i < FP; i++) mem[i] <= fill_val;
    end else if (ram_wren && int'(ram_wraddress) < FP) begin
      mem[ram_wraddress] <= ram_data;
    end
    ram_q <= (int'(ram_rdaddress) < FP) ? mem[ram_rdaddress] : '0;
  end

  always @(negedge CLOCK_50) begin
    if (cmp_valid) begin
      if (cmp_cnt == 0) cmp_first = cyc;
      if (cmp_cnt < 1024) begin
        log_old[cmp_cnt] = cmp_old; log_new[cmp_cnt] = cmp_new;
        log_x[cmp_cnt] = cmp_x;     log_y[cmp_cnt] = cmp_y;
      end
      cmp_last = cyc;
      cmp_cnt++;
    end
    if (ram_wren) begin
      wr_cnt++;
      if (clr_busy && ram_data == '0) zero_wr_cnt++;
    end
    if (clr_done) done_cnt++;
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle(input int n);
    cap_valid = 1'b0; clr_start = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    resetn = 1'b0; cap_valid = 1'b0; clr_start = 1'b0; rd_req = 1'b1; rd_addr = 17'd55;
    cap_x = '0; cap_y = '0; cap_data = '0;
    fill_req = 1'b1; fill_val = '0;
    step(); step(); #1;
    fill_req = 1'b0;
    checks++; if (rd_grant !== 1'b0) begin errors++; $display("FAIL reset_rd_grant: got %0b want 0", rd_grant); end
    checks++; if (ram_rdaddress !== '0) begin errors++; $display("FAIL reset_rdaddress: got %0d want 0", ram_rdaddress); end
    checks++; if (cmp_valid !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valids: got cmp=%0b rd=%0b want 0", cmp_valid, rd_valid); end
    checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr: got busy=%0b done=%0b want 0", clr_busy, clr_done); end
    checks++; if (ram_wren !== 1'b0 || ram_wraddress !== '0 || ram_data !== '0) begin errors++; $display("FAIL reset_wr: got wren=%0b addr=%0d data=%0d want 0", ram_wren, ram_wraddress, ram_data); end
    checks++; if (cap_oob !== 1'b0 || cmp_old !== '0 || cmp_x !== '0) begin errors++; $display("FAIL reset_misc: got oob=%0b old=%0d x=%0d want 0", cap_oob, cmp_old, cmp_x); end
    rd_req = 1'b0; rd_addr = '0; resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    cap_valid = 1'b1; cap_x = 9'd5; cap_y = 8'd2; cap_data = 3'b101;
    step();
    cap_valid = 1'b0;
    checks++; if (ram_rdaddress !== 17'd645) begin errors++; $display("FAIL single_rdaddr: got %0d want 645", ram_rdaddress); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL single_early_wren: got %0b want 0", ram_wren); end
    step();
    checks++; if (ram_wren !== 1'b1 || ram_wraddress !== 17'd645 || ram_data !== 3'd5) begin errors++; $display("FAIL single_write: got wren=%0b addr=%0d data=%0d want 1/645/5", ram_wren, ram_wraddress, ram_data); end
    checks++; if (cmp_valid !== 1'b0) begin errors++; $display("FAIL single_early_cmp: got %0b want 0", cmp_valid); end
    step();
    checks++; if (cmp_valid !== 1'b1 || cmp_old !== 3'd0 || cmp_new !== 3'd5 || cmp_x !== 9'd5 || cmp_y !== 8'd2) begin
      errors++; $display("FAIL single_cmp: got v=%0b old=%0d new=%0d x=%0d y=%0d want 1/0/5/5/2", cmp_valid, cmp_old, cmp_new, cmp_x, cmp_y); end
    step();
    checks++; if (cmp_valid !== 1'b0 || ram_wren !== 1'b0) begin errors++; $display("FAIL single_pulse: got cmp=%0b wren=%0b want 0", cmp_valid, ram_wren); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int bad_old, bad_new, bad_xy;
    logic [DATA_W-1:0] d;
    cmp_cnt = 0;
    for (int p = 0; p < 2; p++) begin
      for (int x = 0; x < LINE_STRIDE; x++) begin
        d = DATA_W'(x);
        cap_valid = 1'b1; cap_x = X_W'(x); cap_y = 8'd1; cap_data = (p == 1) ? ~d : d;
        step();
      end
    end
    idle(5);
    checks++; if (cmp_cnt != 640) begin errors++; $display("FAIL b2b_count: got %0d want 640", cmp_cnt); end
    checks++; if (cmp_last - cmp_first != 639) begin errors++; $display("FAIL b2b_span: got %0d want 639", cmp_last - cmp_first); end
    bad_old = 0; bad_new = 0; bad_xy = 0;
    for (int i = 0; i < 640; i++) begin
      d = DATA_W'(i % LINE_STRIDE);
      if (log_new[i] !== ((i >= 320) ? ~d : d)) bad_new++;
      if (log_old[i] !== ((i >= 320) ? d : 3'd0)) bad_old++;
      if (log_x[i] !== X_W'(i % LINE_STRIDE) || log_y[i] !== 8'd1) bad_xy++;
    end
    checks++; if (bad_old != 0) begin errors++; $display("FAIL b2b_old: got %0d bad entries want 0", bad_old); end
    checks++; if (bad_new != 0) begin errors++; $display("FAIL b2b_new: got %0d bad entries want 0", bad_new); end
    checks++; if (bad_xy != 0) begin errors++; $display("FAIL b2b_xy: got %0d bad entries want 0", bad_xy); end
  endtask

  task automatic test_contention();
    logic g_hist [16];
    logic prev_cap, exp_g, exp_v;
    cap_valid = 1'b1; cap_x = 9'd100; cap_y = 8'd0; cap_data = 3'd6;
    step();
    idle(4);
    prev_cap = 1'b0;
    for (int k = 0; k < 14; k++) begin
      cap_valid = (k % 2 == 0) && (k < 12); cap_x = X_W'(k); cap_y = 8'd3; cap_data = 3'd1;
      rd_req = (k < 12); rd_addr = 17'd100;
      #1;
      exp_g = rd_req && !prev_cap;
      g_hist[k] = exp_g;
      exp_v = (k >= 2) ? g_hist[k-2] : 1'b0;
      checks++; if (rd_grant !== exp_g) begin errors++; $display("FAIL cont_grant[%0d]: got %0b want %0b", k, rd_grant, exp_g); end
      checks++; if (rd_valid !== exp_v) begin errors++; $display("FAIL cont_valid[%0d]: got %0b want %0b", k, rd_valid, exp_v); end
      if (exp_v) begin
        checks++; if (rd_data !== 3'd6) begin errors++; $display("FAIL cont_data[%0d]: got %0d want 6", k, rd_data); end
      end
      prev_cap = cap_valid;
      step();
    end
    rd_req = 1'b0;
    idle(3);
  endtask

  task automatic test_oob();
    cmp_cnt = 0; wr_cnt = 0;
    checks++; if (cap_oob !== 1'b0) begin errors++; $display("FAIL oob_initial: got %0b want 0", cap_oob); end
    cap_valid = 1'b1; cap_x = 9'd320; cap_y = 8'd0; cap_data = 3'd7;
    step();
    checks++; if (cap_oob !== 1'b1) begin errors++; $display("FAIL oob_x: got %0b want 1", cap_oob); end
    cap_x = 9'd0; cap_y = 8'd240;
    step();
    cap_x = 9'd0; cap_y = 8'd10;
    step();
    idle(5);
    checks++; if (cmp_cnt != 0 || wr_cnt != 0) begin errors++; $display("FAIL oob_dropped: got cmp=%0d wr=%0d want 0/0", cmp_cnt, wr_cnt); end
    cap_valid = 1'b1; cap_x = 9'd319; cap_y = 8'd9; cap_data = 3'd4;
    step();
    idle(5);
    checks++; if (cmp_cnt != 1 || wr_cnt != 1) begin errors++; $display("FAIL oob_last_pixel: got cmp=%0d wr=%0d want 1/1", cmp_cnt, wr_cnt); end
    checks++; if (cmp_x !== 9'd319 || cmp_y !== 8'd9 || cmp_new !== 3'd4) begin errors++; $display("FAIL oob_last_cmp: got x=%0d y=%0d new=%0d want 319/9/4", cmp_x, cmp_y, cmp_new); end
    checks++; if (cap_oob !== 1'b1) begin errors++; $display("FAIL oob_sticky: got %0b want 1", cap_oob); end
  endtask

  task automatic test_clear_under_load();
    int n, bad_keep, bad_zero, bad_v;
    logic [DATA_W-1:0] exp_d;
    fill_req = 1'b1; fill_val = 3'd7;
    step();
    fill_req = 1'b0;
    wr_cnt = 0; zero_wr_cnt = 0; done_cnt = 0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL clr_busy_start: got %0b want 1", clr_busy); end
    for (int k = 0; k < 640; k++) begin
      cap_valid = (k % 2 == 0); cap_x = X_W'(k / 2); cap_y = 8'd9; cap_data = 3'd3;
      step();
    end
    cap_valid = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      clr_start = (k == 500);
      step();
    end
    clr_start = 1'b0;
    for (int k = 0; k < 640; k++) begin
      cap_valid = (k % 2 == 0); cap_x = X_W'(k / 2); cap_y = 8'd0; cap_data = 3'd2;
      step();
    end
    cap_valid = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin step(); n++; end
    checks++; if (done_cnt == 0) begin errors++; $display("FAIL clr_timeout: got no clr_done in %0d cycles want one", n); end
    idle(3);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL clr_done_count: got %0d want 1", done_cnt); end
    checks++; if (zero_wr_cnt != FP) begin errors++; $display("FAIL clr_writes: got %0d want %0d", zero_wr_cnt, FP); end
    checks++; if (wr_cnt != FP + 640) begin errors++; $display("FAIL clr_total_writes: got %0d want %0d", wr_cnt, FP + 640); end
    checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin errors++; $display("FAIL clr_idle: got busy=%0b done=%0b want 0/0", clr_busy, clr_done); end
    bad_keep = 0; bad_zero = 0; bad_v = 0;
    for (int a = 0; a < FP + 2; a++) begin
      rd_req = (a < FP); rd_addr = ADDR_W'(a);
      #1;
      if (a >= 2) begin
        exp_d = (a - 2 < LINE_STRIDE) ? 3'd2 : 3'd0;
        if (rd_valid !== 1'b1) bad_v++;
        else if (rd_data !== exp_d) begin
          if (a - 2 < LINE_STRIDE) bad_keep++; else bad_zero++;
        end
      end
      step();
    end
    rd_req = 1'b0;
    checks++; if (bad_v != 0) begin errors++; $display("FAIL scan_valid: got %0d missing want 0", bad_v); end
    checks++; if (bad_keep != 0) begin errors++; $display("FAIL scan_kept: got %0d bad want 0", bad_keep); end
    checks++; if (bad_zero != 0) begin errors++; $display("FAIL scan_zero: got %0d bad want 0", bad_zero); end
    idle(2);
  endtask

  task automatic test_reset_mid_clear();
    int n;
    cap_valid = 1'b1; cap_x = 9'd400; cap_y = 8'd0;
    step();
    cap_valid = 1'b0;
    checks++; if (cap_oob !== 1'b1) begin errors++; $display("FAIL rmc_oob_set: got %0b want 1", cap_oob); end
    done_cnt = 0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    idle(999);
    cap_valid = 1'b1; cap_x = 9'd10; cap_y = 8'd5; cap_data = 3'd5;
    step();
    cap_valid = 1'b0; resetn = 1'b0;
    step();
    resetn = 1'b1;
    cmp_cnt = 0; wr_cnt = 0;
    checks++; if (clr_busy !== 1'b0 || cap_oob !== 1'b0) begin errors++; $display("FAIL rmc_state: got busy=%0b oob=%0b want 0/0", clr_busy, cap_oob); end
    checks++; if (ram_wren !== 1'b0 || cmp_valid !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL rmc_outputs: got wren=%0b cmp=%0b rd=%0b want 0", ram_wren, cmp_valid, rd_valid); end
    idle(4);
    checks++; if (cmp_cnt != 0 || wr_cnt != 0 || done_cnt != 0) begin errors++; $display("FAIL rmc_flushed: got cmp=%0d wr=%0d done=%0d want 0", cmp_cnt, wr_cnt, done_cnt); end
    zero_wr_cnt = 0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    checks++; if (ram_wren !== 1'b1 || ram_wraddress !== '0) begin errors++; $display("FAIL rmc_restart0: got wren=%0b addr=%0d want 1/0", ram_wren, ram_wraddress); end
    step();
    checks++; if (ram_wraddress !== 17'd1) begin errors++; $display("FAIL rmc_restart1: got %0d want 1", ram_wraddress); end
    n = 0;
    while (done_cnt == 0 && n < 4000) begin step(); n++; end
    checks++; if (done_cnt != 1 || zero_wr_cnt != FP) begin errors++; $display("FAIL rmc_complete: got done=%0d writes=%0d want 1/%0d", done_cnt, zero_wr_cnt, FP); end
    idle(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_contention();
    test_oob();
    test_clear_under_load();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
